// File: rtl/seq_sub_pkg.sv
// rtl/seq_sub_pkg.sv - shared widths and FSM state type for the sequential subtractor
package seq_sub_pkg;
  localparam int WIDTH   = 16;
  localparam int SLICE_W = 4;
  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int KW      = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/sub4_slice.sv
// rtl/sub4_slice.sv - 4-bit borrow-select subtract slice, purely combinational
module sub4_slice
  import seq_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo
);
  // Both borrow cases are formed up front; the MSB of each wide result is its borrow-out.
  logic [SLICE_W:0] d0;
  logic [SLICE_W:0] d1;

  always_comb begin
    d0 = {1'b0, a} - {1'b0, b};
    d1 = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, 1'b1};
    d  = bi ? d1[SLICE_W-1:0] : d0[SLICE_W-1:0];
    bo = bi ? d1[SLICE_W] : d0[SLICE_W];
  end
endmodule

// File: rtl/seq_sub16.sv
// rtl/seq_sub16.sv - sequential 16-bit subtractor, one 4-bit slice per cycle
module seq_sub16
  import seq_sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             busy
);
  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_d, diff_q;
  logic [KW-1:0]      k_q;
  logic               borrow_q, bout_q, zero_q;
  logic [SLICE_W-1:0] a_sl, b_sl, d_sl;
  logic               bo_sl;
  logic               last_slice;

  assign last_slice = (k_q == KW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_sl  = a_q[int'(k_q) * SLICE_W +: SLICE_W];
    b_sl  = b_q[int'(k_q) * SLICE_W +: SLICE_W];
    acc_d = acc_q;
    acc_d[int'(k_q) * SLICE_W +: SLICE_W] = d_sl;
  end

  sub4_slice u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .bi (borrow_q),
    .d  (d_sl),
    .bo (bo_sl)
  );

  // The partial difference builds up in acc_q so diff keeps the previous result until the last slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bin;
        k_q      <= '0;
      end
      if (state_q == RUN) begin
        acc_q    <= acc_d;
        borrow_q <= bo_sl;
        k_q      <= k_q + KW'(1);
        if (last_slice) begin
          diff_q <= acc_d;
          bout_q <= bo_sl;
          zero_q <= (acc_d == '0);
        end
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_seq_sub16.sv
// tb/tb_seq_sub16.sv - scoreboard bench for seq_sub16
module tb_seq_sub16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        bout;
  logic        zero;
  logic        busy;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  seq_sub16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one handshake per negedge seen with out_valid && out_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(diff), 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("diff", 32'(diff), 32'(e.diff));
          chk("bout", 32'(bout), 32'(e.bout));
          chk("zero", 32'(zero), 32'(e.zero));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Offers one operand pair; returns at accept edge + 1.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input logic [15:0] ed, input logic eb, input logic ez, input bit push);
    exp_t e;
    wait_ready();
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      e.diff = ed; e.bout = eb; e.zero = ez;
      exp_q.push_back(e);
    end
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  initial begin
    int prev;
    int n;
    logic [15:0] ra, rb;
    logic        rbin;
    logic [16:0] full;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("latency_out_valid", 32'(out_valid), 32'(i == 4));
    end

    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Backpressure with a second pair continuously offered.
    wait_ready();
    out_ready = 1'b0;
    send(16'h0300, 16'h0100, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b1);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin
      chk("refuse_in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid_arrives", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_diff", 32'(diff), 32'h0200);
      chk("bp_bout", 32'(bout), 32'd0);
      chk("bp_zero", 32'(zero), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset during the second RUN cycle, with a pair that would leave a borrow set.
    send(16'h0000, 16'h0001, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_diff", 32'(diff), 32'd0);
    send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    // Back-to-back random operands, out_ready tied high.
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom_range(1, 0));
      if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rbin = 1'b1; end
      full = {1'b0, ra} - {1'b0, rb} - {16'h0, rbin};
      send(ra, rb, rbin, full[15:0], full[16], full[15:0] == 16'h0, 1'b1);
      if (i > 0) chk("accept_spacing", 32'(acc_cyc - prev), 32'd6);
      prev = acc_cyc;
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
